fir_mac16: RTL

Sixteen-tap FIR filter engine that sits directly downstream of the 16-entry 24-bit sample history buffer in the mixer datapath. On each new-sample strobe it pops the buffer's read pointer, sweeps offsets 0..15, and multiply-accumulates each sample against a run-time-loadable coefficient table. It then emits one rounded, saturated 24-bit output sample with a one-cycle valid strobe. It is the consumer of the buffer's offset/pop read port and the producer for the downstream mixer stage.

---
 rtl/dmix_pkg.sv | 41 ++++
 rtl/fir_coef_ram.sv | 25 ++
 rtl/fir_mac16.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dmix_pkg.sv
// Shared mixer-datapath definitions: sample/coefficient widths, FIR sequencer states
// and the output rounding/saturation helpers reused by other mixer stages.
package dmix_pkg;

  localparam int SAMPLE_W  = 24;
  localparam int COEF_W    = 18;
  localparam int COEF_FRAC = 16;
  localparam int TAPS      = 16;
  localparam int TAP_AW    = 4;
  localparam int PROD_W    = SAMPLE_W + COEF_W;
  localparam int ACC_W     = PROD_W + TAP_AW;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (SAMPLE_W - 1)));
  localparam logic signed [ACC_W-1:0] ROUND_HALF =
    {{(ACC_W - COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_DRAIN = 2'd2
  } fir_state_e;

  // Round half up, then drop the coefficient fraction bits (arithmetic shift).
  function automatic logic signed [ACC_W-1:0] round_frac(input logic signed [ACC_W-1:0] value);
    logic signed [ACC_W-1:0] biased;
    biased = value + ROUND_HALF;
    return biased >>> COEF_FRAC;
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [ACC_W-1:0] value);
    if (value > SAT_MAX) begin
      return SAT_MAX[SAMPLE_W-1:0];
    end else if (value < SAT_MIN) begin
      return SAT_MIN[SAMPLE_W-1:0];
    end else begin
      return value[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fir_coef_ram.sv
// 16 x 18-bit coefficient register file: synchronous write, asynchronous read.
module fir_coef_ram
  import dmix_pkg::*;
(
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [TAP_AW-1:0]        waddr_i,
  input  logic signed [COEF_W-1:0] wdata_i,
  input  logic [TAP_AW-1:0]        raddr_i,
  output logic signed [COEF_W-1:0] rdata_o
);

  logic signed [COEF_W-1:0] r_mem [TAPS];

  // NOTE: storage arrays carry no reset; a reset port would turn the table into
  // 288 reset flops, and software always loads it before the first run.
  always_ff @(posedge clk) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/fir_mac16.sv
// Sixteen-tap FIR engine: pops the history buffer, sweeps offsets 0..15 with one
// MAC per cycle, then emits a rounded, saturated sample with a one-cycle strobe.
module fir_mac16
  import dmix_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  output logic                       hist_pop_o,
  output logic [TAP_AW-1:0]          hist_offset_o,
  input  logic signed [SAMPLE_W-1:0] hist_data_i,
  input  logic                       coef_we_i,
  input  logic [TAP_AW-1:0]          coef_addr_i,
  input  logic signed [COEF_W-1:0]   coef_data_i,
  output logic signed [SAMPLE_W-1:0] data_o,
  output logic                       valid_o,
  output logic                       busy_o,
  output logic                       overrun_o
);

  fir_state_e                 r_state;
  fir_state_e                 w_next_state;
  logic [TAP_AW-1:0]          r_k;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [PROD_W-1:0]   r_prod;
  logic signed [SAMPLE_W-1:0] r_data;
  logic                       r_valid;
  logic                       r_overrun;

  logic                       w_pop;
  logic                       w_busy;
  logic [TAP_AW-1:0]          w_offset;
  logic signed [COEF_W-1:0]   w_coef;
  logic signed [PROD_W-1:0]   w_product;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [SAMPLE_W-1:0] w_result;

  fir_coef_ram u_coef_ram (
    .clk     (clk),
    .we_i    (coef_we_i),
    .waddr_i (coef_addr_i),
    .wdata_i (coef_data_i),
    .raddr_i (r_k),
    .rdata_o (w_coef)
  );

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through the
  // case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_busy       = 1'b0;
    w_offset     = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i && !rst) begin
          w_pop        = 1'b1;
          w_next_state = ST_MAC;
        end
      end
      ST_MAC: begin
        w_busy   = 1'b1;
        w_offset = r_k;
        if (r_k == TAP_AW'(TAPS - 1)) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_busy       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // One-stage pipelined MAC: the product register lags the accumulator by a tap,
  // so the last product is folded in during DRAIN.
  assign w_product  = PROD_W'(hist_data_i) * PROD_W'(w_coef);
  assign w_prod_ext = ACC_W'(r_prod);
  assign w_sum      = r_acc + w_prod_ext;
  assign w_result   = sat_sample(round_frac(w_sum));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_prod    <= '0;
      r_k       <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_acc  <= '0;
            r_prod <= '0;
            r_k    <= '0;
          end
        end
        ST_MAC: begin
          r_prod <= w_product;
          r_acc  <= w_sum;
          r_k    <= r_k + TAP_AW'(1);
        end
        ST_DRAIN: begin
          r_data  <= w_result;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
      if (start_i && w_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign hist_pop_o    = w_pop;
  assign hist_offset_o = w_offset;
  assign busy_o        = w_busy;
  assign data_o        = r_data;
  assign valid_o       = r_valid;
  assign overrun_o     = r_overrun;

endmodule
